ex_muldiv_seq: RTL and testbench

- Iterative sequencer for RV32M multiply/divide/remainder ops issued from the EX stage.
- Accepts one op from the EX stage, runs a shared shift-add / restoring-divide datapath for BIT_W cycles, and holds the pipeline via a stall output.
- Presents a one-cycle result strobe, which the EX/MEM register captures in place of the ALU result.
- Sits beside the ALU inside the EX stage.

---
 rtl/ex_muldiv_seq.sv | 185 ++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide/remainder sequencer beside the EX-stage ALU.
// One shift-add or restoring-divide step per cycle; the latency is the same for every op.
module ex_muldiv_seq #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [2:0]       op_in,
  input  logic [BIT_W-1:0] opA_in,
  input  logic [BIT_W-1:0] opB_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             done_out,
  output logic [BIT_W-1:0] result_out,
  output logic             busy_out
);
  localparam int AW = 2*BIT_W + 1;
  localparam int CW = $clog2(BIT_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [BIT_W-1:0] r_a;
  logic [BIT_W-1:0] r_b;
  logic [BIT_W-1:0] r_result;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_bzero;
  logic             r_done;

  logic             w_accept;
  logic             w_sa;
  logic             w_sb;
  logic             w_neg_in;
  logic             w_qbit;
  logic [BIT_W-1:0] w_mag_a;
  logic [BIT_W-1:0] w_mag_b;
  logic [BIT_W:0]   w_rem_sh;
  logic [BIT_W:0]   w_rem_sub;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_mul_next;
  logic [2*BIT_W-1:0] w_prod;
  logic [BIT_W-1:0] w_quo;
  logic [BIT_W-1:0] w_rem;
  logic [BIT_W-1:0] w_fix;

  function automatic logic [BIT_W-1:0] neg_if(input logic n, input logic [BIT_W-1:0] v);
    return n ? ({BIT_W{1'b0}} - v) : v;
  endfunction

  function automatic logic [2*BIT_W-1:0] neg_if_w(input logic n, input logic [2*BIT_W-1:0] v);
    return n ? ({(2*BIT_W){1'b0}} - v) : v;
  endfunction

  // Operand conditioning at accept, one datapath step, and final sign fix / half select.
  always_comb begin
    w_accept = (r_state == S_IDLE) && valid_in && !flush_in;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        w_sa = opA_in[BIT_W-1];
        w_sb = opB_in[BIT_W-1];
      end
      OP_MULHSU: begin
        w_sa = opA_in[BIT_W-1];
        w_sb = 1'b0;
      end
      default: begin
        w_sa = 1'b0;
        w_sb = 1'b0;
      end
    endcase
    w_mag_a  = neg_if(w_sa, opA_in);
    w_mag_b  = neg_if(w_sb, opB_in);
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    w_neg_in = (op_in == OP_REM) ? w_sa : (w_sa ^ w_sb);

    w_rem_sh   = {r_acc[BIT_W-1:0], r_a[BIT_W-1]};
    w_rem_sub  = w_rem_sh - {1'b0, r_b};
    w_qbit     = !w_rem_sub[BIT_W];
    w_addend   = r_a[BIT_W-1] ? {{(BIT_W+1){1'b0}}, r_b} : {AW{1'b0}};
    w_mul_next = {r_acc[AW-2:0], 1'b0} + w_addend;

    w_prod = neg_if_w(r_neg, r_acc[2*BIT_W-1:0]);
    w_quo  = r_bzero ? {BIT_W{1'b1}} : neg_if(r_neg, r_a);
    w_rem  = neg_if(r_neg, r_acc[BIT_W-1:0]);
    case (r_op)
      OP_MUL:                       w_fix = w_prod[BIT_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*BIT_W-1:BIT_W];
      OP_DIV, OP_DIVU:              w_fix = w_quo;
      default:                      w_fix = w_rem;
    endcase
  end

  // Sequencer FSM with its datapath registers and registered result/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_a      <= {BIT_W{1'b0}};
      r_b      <= {BIT_W{1'b0}};
      r_result <= {BIT_W{1'b0}};
      r_acc    <= {AW{1'b0}};
      r_cnt    <= CNT_ZERO;
      r_neg    <= 1'b0;
      r_bzero  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op    <= op_in;
            r_a     <= w_mag_a;
            r_b     <= w_mag_b;
            r_neg   <= w_neg_in;
            r_bzero <= (opB_in == {BIT_W{1'b0}});
            r_acc   <= {AW{1'b0}};
            r_cnt   <= CNT_LAST;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (flush_in) begin
            r_state <= S_IDLE;
          end else begin
            // r_a supplies operand bits MSB-first; for divide it collects quotient bits.
            if (r_op[2]) begin
              r_acc <= {{(AW-BIT_W){1'b0}}, (w_qbit ? w_rem_sub[BIT_W-1:0] : w_rem_sh[BIT_W-1:0])};
              r_a   <= {r_a[BIT_W-2:0], w_qbit};
            end else begin
              r_acc <= w_mul_next;
              r_a   <= {r_a[BIT_W-2:0], 1'b0};
            end
            r_cnt   <= r_cnt - CNT_ONE;
            r_state <= (r_cnt == CNT_ZERO) ? S_FIX : S_CALC;
          end
        end
        S_FIX: begin
          if (flush_in) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_out  = w_accept || (r_state == S_CALC) || (r_state == S_FIX);
  assign done_out   = r_done;
  assign result_out = r_result;
  assign busy_out   = (r_state != S_IDLE);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed RV32M cases, flush/reset, then random ops
// checked against an arithmetic reference model.
module tb_ex_muldiv_seq;
  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [2:0]  op_in;
  logic [31:0] opA_in;
  logic [31:0] opB_in;
  logic        flush_in;
  logic        stall_out;
  logic        done_out;
  logic [31:0] result_out;
  logic        busy_out;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv_seq #(.BIT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op_in(op_in),
    .opA_in(opA_in), .opB_in(opB_in), .flush_in(flush_in),
    .stall_out(stall_out), .done_out(done_out), .result_out(result_out),
    .busy_out(busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, track it to done_out and check latency, stall profile and result.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic hold, input logic [31:0] exp);
    logic        seen;
    logic        stall_ok;
    logic        stall_at_done;
    logic [31:0] got;
    int          lat;
    @(negedge clk);
    valid_in = 1'b1; op_in = op; opA_in = a; opB_in = b;
    #1;
    chk($sformatf("stall_c0 op%0d", op), 32'(stall_out), 32'd1);
    chk($sformatf("idle_c0 op%0d", op), 32'(busy_out), 32'd0);
    @(posedge clk);
    #1;
    if (!hold) valid_in = 1'b0;
    seen = 1'b0; stall_ok = 1'b1; stall_at_done = 1'b1; got = 32'd0; lat = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (done_out) begin
        seen = 1'b1; lat = k; got = result_out; stall_at_done = stall_out;
      end else if (!stall_out || !busy_out) begin
        stall_ok = 1'b0;
      end
    end
    chk($sformatf("latency op%0d", op), 32'(lat), 32'd34);
    chk($sformatf("stall_calc op%0d", op), 32'(stall_ok), 32'd1);
    chk($sformatf("stall_done op%0d", op), 32'(stall_at_done), 32'd0);
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), got, exp);
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("done_pulse op%0d", op), 32'(done_out), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        any_done;

    rst_n = 1'b0; valid_in = 1'b0; op_in = 3'd0; opA_in = 32'd0; opB_in = 32'd0; flush_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_result", result_out, 32'd0);
    rst_n = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd100, 32'd7, 1'b0, 32'd14);
    do_op(3'd7, 32'd100, 32'd7, 1'b0, 32'd2);
    do_op(3'd4, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF);
    do_op(3'd6, 32'd5, 32'd0, 1'b0, 32'd5);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);

    // Flush while idle with valid: the op must not be accepted.
    @(negedge clk);
    valid_in = 1'b1; op_in = 3'd4; opA_in = 32'd50; opB_in = 32'd5; flush_in = 1'b1;
    #1;
    chk("flush_idle_stall", 32'(stall_out), 32'd0);
    @(negedge clk);
    valid_in = 1'b0; flush_in = 1'b0;
    #1;
    chk("flush_idle_busy", 32'(busy_out), 32'd0);

    // Flush a DIV at cycle 10.
    @(negedge clk);
    valid_in = 1'b1; op_in = 3'd4; opA_in = 32'd1000; opB_in = 32'd7;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    #1;
    chk("flush_busy", 32'(busy_out), 32'd0);
    chk("flush_stall", 32'(stall_out), 32'd0);
    any_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_out) any_done = 1'b1;
    end
    chk("flush_no_done", 32'(any_done), 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 1'b0, 32'd12);

    // Asynchronous reset at cycle 20 of a MUL.
    @(negedge clk);
    valid_in = 1'b1; op_in = 3'd0; opA_in = 32'd11; opB_in = 32'd13;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_out), 32'd0);
    chk("arst_stall", 32'(stall_out), 32'd0);
    chk("arst_done", 32'(done_out), 32'd0);
    chk("arst_result", result_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back: DIVU held valid through DONE, then REMU.
    do_op(3'd5, 32'd9, 32'd3, 1'b1, 32'd3);
    do_op(3'd7, 32'd9, 32'd4, 1'b0, 32'd1);

    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, 1'b0, ref_model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
